// File: rtl/pwm_peripheral.sv
// PWM peripheral: one shared PWM waveform fanned out to 16 pins, each pin
// independently forced low, forced high, or following the waveform.

module pwm_pin (
  input  logic clk,
  input  logic rst_n,
  input  logic en_out,
  input  logic en_pwm,
  input  logic pwm_level,
  output logic q
);
  // Enable has priority over mode select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q <= 1'b0;
    else if (!en_out) q <= 1'b0;
    else if (!en_pwm) q <= 1'b1;
    else              q <= pwm_level;
  end
endmodule

module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);
  localparam int         NUM_PINS = 16;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]          prescaler;
  logic [7:0]          pwm_cnt;
  logic [7:0]          duty_shadow;
  logic                tick;
  logic                wrap;
  logic                pwm_level;
  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // With CLK_DIV=1 the prescaler sits at 0 and tick is always high
  assign tick = (prescaler == DIV_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Duty only takes effect on the wrap edge so mid-period writes cannot glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) duty_shadow <= pwm_duty_cycle;
    end
  end

  // 0xFF is treated as true 100% rather than 255/256
  assign pwm_level = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    pwm_pin u_pin (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_out    (en_out[i]),
      .en_pwm    (en_pwm[i]),
      .pwm_level (pwm_level),
      .q         (out[i])
    );
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: static pin checks plus per-period high-time
// scoreboard measured on out[0].

module tb_pwm_peripheral;
  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;
  localparam int BOUND   = PERIOD + 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Wait (bounded) for period_start; returns clocks waited and out[0] high count
  task automatic wait_ps(output int n, output int hi);
    n = 0; hi = 0;
    while (n < BOUND) begin
      @(negedge clk);
      n++;
      hi += int'(out[0]);
      if (period_start) break;
    end
    if (!period_start) chk("period_start_timeout", 0, 1);
  endtask

  // Called right after period_start was seen; measures one period of out[0]
  // and checks it against the next scoreboard entry. Optionally rewrites the
  // duty register after sample write_at.
  task automatic measure(input string tag, input int write_at, input logic [7:0] new_duty);
    int n, hi, oth, exp_hi;
    n = 0; hi = 0; oth = 0;
    while (n < BOUND) begin
      @(negedge clk);
      n++;
      hi += int'(out[0]);
      if (out[15:1] != 15'h0) oth++;
      if (n == write_at) pwm_duty_cycle = new_duty;
      if (period_start) break;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 0, 1);
      exp_hi = -1;
    end else begin
      exp_hi = exp_q.pop_front();
    end
    chk({tag, "_high"}, hi, exp_hi);
    chk({tag, "_period"}, n, PERIOD);
    chk({tag, "_other_pins"}, oth, 0);
  endtask

  initial begin
    int n, hi;
    rst_n = 1'b0;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;

    #12;
    chk("reset_out", int'(out), 0);
    chk("reset_ps", int'(period_start), 0);

    // Release, first period_start arrives exactly one period later
    @(negedge clk); rst_n = 1'b1;
    wait_ps(n, hi);
    chk("first_ps_delay", n, PERIOD);
    chk("first_period_low", hi, 0);
    exp_q.push_back(0);
    measure("idle", 0, 8'h00);

    // Static on, duty ignored
    set_en(16'hFFFF, 16'h0000);
    pwm_duty_cycle = 8'h55;
    @(negedge clk);
    chk("static_on", int'(out), 16'hFFFF);
    repeat (40) @(negedge clk);
    chk("static_on_hold", int'(out), 16'hFFFF);

    // Enable priority: pwm select without enable stays low
    set_en(16'h0000, 16'hFFFF);
    @(negedge clk);
    chk("en_priority", int'(out), 0);

    // 50% duty on pin 0
    set_en(16'h0001, 16'h0001);
    pwm_duty_cycle = 8'h80;
    wait_ps(n, hi);
    exp_q.push_back(8'h80 * CLK_DIV);
    measure("duty80", 0, 8'h00);

    // 0% then 100% across two periods
    pwm_duty_cycle = 8'h00;
    wait_ps(n, hi);
    exp_q.push_back(0);
    measure("duty00", 0, 8'h00);
    pwm_duty_cycle = 8'hFF;
    wait_ps(n, hi);
    exp_q.push_back(PERIOD);
    exp_q.push_back(PERIOD);
    measure("dutyFF_a", 0, 8'h00);
    measure("dutyFF_b", 0, 8'h00);

    // Mid-period write at pwm_cnt=0x10 waits for the wrap
    pwm_duty_cycle = 8'h40;
    wait_ps(n, hi);
    exp_q.push_back(8'h40 * CLK_DIV);
    exp_q.push_back(8'hC0 * CLK_DIV);
    measure("mid_write_old", 16 * CLK_DIV, 8'hC0);
    measure("mid_write_new", 0, 8'h00);

    // Write landing on the wrap edge itself is captured
    pwm_duty_cycle = 8'h80;
    wait_ps(n, hi);
    exp_q.push_back(8'h80 * CLK_DIV);
    exp_q.push_back(8'h20 * CLK_DIV);
    measure("wrap_write_old", PERIOD - 1, 8'h20);
    measure("wrap_write_new", 0, 8'h00);

    // Asynchronous reset in the high phase, then recovery
    pwm_duty_cycle = 8'h80;
    wait_ps(n, hi);
    repeat (100) @(negedge clk);
    chk("pre_reset_high", int'(out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(out), 0);
    chk("async_reset_ps", int'(period_start), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ps(n, hi);
    chk("post_reset_ps_delay", n, PERIOD);
    chk("post_reset_first_low", hi, 0);
    exp_q.push_back(8'h80 * CLK_DIV);
    measure("post_reset_duty80", 0, 8'h00);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
